// File: rtl/uart_pkg.sv
// Shared definitions for the UART peripherals: register map, status bit
// positions, receiver state encoding and default bit timing.
package uart_pkg;

   // 12 MHz system clock / 115200 baud
   localparam int unsigned UART_CLKS_PER_BIT = 104;

   // Register offsets (addr[1:0])
   localparam logic [1:0] UART_RX_DATA   = 2'd0;
   localparam logic [1:0] UART_RX_STATUS = 2'd1;

   // STATUS register bit positions
   localparam int unsigned ST_READY   = 0;
   localparam int unsigned ST_OVERRUN = 1;
   localparam int unsigned ST_FRAME   = 2;
   localparam int unsigned ST_FULL    = 3;

   // Receiver FSM states
   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_BREAK
   } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Small receive FIFO. Head is read combinationally from storage; a push
// into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module rx_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             empty,
   output logic             full
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   // Qualify requests against occupancy; a pop makes room for a push
   always_comb begin
      do_pop  = pop && (count != '0);
      do_push = push && ((count != FULL_CNT) || do_pop);
   end

   // Storage write
   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= push_data;
   end

   // Pointers and occupancy count
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign head  = mem[rd_ptr];
   assign empty = (count == '0);
   assign full  = (count == FULL_CNT);

endmodule

// File: rtl/uart_rx.sv
// Bus-mapped 8N1 UART receiver with receive FIFO and STATUS register.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] addr,
   input  logic       rd_en,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   input  logic       wr_en,
   input  logic [7:0] wr_data,
   input  logic       rx,
   output logic       rx_ready
);

   localparam int unsigned TW = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT/2 - 1);
   localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);

   logic            rx_m;
   logic            rx_s;
   logic            rx_p;
   rx_state_t       state;
   logic [TW-1:0]   timer;
   logic [2:0]      bit_idx;
   logic [7:0]      shift;
   logic            stop_tick;
   logic            push;
   logic            pop;
   logic [7:0]      head;
   logic            empty;
   logic            full;
   logic            overrun;
   logic            frame_err;
   logic            ovr_set;
   logic            frm_set;
   logic            status_wr;
   logic [7:0]      status;
   logic            unused_wr_bits;

   assign unused_wr_bits = &{1'b0, wr_data[7:3], wr_data[0]};

   // Two-flop synchronizer plus one delay flop for falling-edge detection
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
         rx_p <= 1'b1;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
         rx_p <= rx_s;
      end
   end

   // Stop-bit sample is decoded from FSM state so the push lands on the
   // same edge as the sample, making the byte visible one cycle later.
   always_comb begin
      stop_tick = (state == RX_STOP) && (timer == T_FULL);
      push      = stop_tick && rx_s;
      frm_set   = stop_tick && !rx_s;
      pop       = rd_en && (addr == UART_RX_DATA) && !empty;
      ovr_set   = push && full && !pop;
      status_wr = wr_en && (addr == UART_RX_STATUS);
   end

   // Frame receiver FSM: start validation, LSB-first data, stop check, break wait
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= RX_IDLE;
         timer   <= '0;
         bit_idx <= '0;
         shift   <= '0;
      end else begin
         case (state)
            RX_IDLE: begin
               if (rx_p && !rx_s) begin
                  state <= RX_START;
                  timer <= '0;
               end
            end
            RX_START: begin
               if (timer == T_HALF) begin
                  timer   <= '0;
                  bit_idx <= '0;
                  state   <= rx_s ? RX_IDLE : RX_DATA;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            RX_DATA: begin
               if (timer == T_FULL) begin
                  shift[bit_idx] <= rx_s;
                  timer          <= '0;
                  bit_idx        <= bit_idx + 1'b1;
                  if (bit_idx == 3'd7)
                     state <= RX_STOP;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            RX_STOP: begin
               if (timer == T_FULL) begin
                  timer <= '0;
                  state <= rx_s ? RX_IDLE : RX_BREAK;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            RX_BREAK: begin
               if (rx_s)
                  state <= RX_IDLE;
            end
            default: state <= RX_IDLE;
         endcase
      end
   end

   rx_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (shift),
      .pop       (pop),
      .head      (head),
      .empty     (empty),
      .full      (full)
   );

   // Sticky error flags: write-1-to-clear, a same-cycle set wins
   always_ff @(posedge clk) begin
      if (rst) begin
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         overrun   <= (overrun   && !(status_wr && wr_data[ST_OVERRUN])) || ovr_set;
         frame_err <= (frame_err && !(status_wr && wr_data[ST_FRAME]))   || frm_set;
      end
   end

   // STATUS register image
   always_comb begin
      status             = '0;
      status[ST_READY]   = !empty;
      status[ST_OVERRUN] = overrun;
      status[ST_FRAME]   = frame_err;
      status[ST_FULL]    = full;
   end

   // Registered bus read response
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_en;
         if (rd_en) begin
            case (addr)
               UART_RX_DATA:   rd_data <= empty ? '0 : head;
               UART_RX_STATUS: rd_data <= status;
               default:        rd_data <= '0;
            endcase
         end
      end
   end

   assign rx_ready = !empty;

endmodule

// File: tb/tb_uart_rx.sv
// Directed, table-driven bench for uart_rx with CLKS_PER_BIT = 16, FIFO_DEPTH = 4.
module tb_uart_rx;

   localparam int unsigned CPB   = 16;
   localparam int unsigned DEPTH = 4;

   typedef enum int unsigned {OP_FRAME, OP_READ, OP_WRITE, OP_LOW, OP_HIGH} op_t;

   typedef struct {
      op_t         op;
      logic [1:0]  a;
      logic [7:0]  d;
      logic        stop;
      int unsigned n;
      logic [7:0]  exp;
      logic        exp_rdy;
      string       name;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] addr;
   logic       rd_en;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       rx;
   logic       rx_ready;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   vec_t        vecs[$];

   always #5 clk = ~clk;

   uart_rx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .addr     (addr),
      .rd_en    (rd_en),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .rx       (rx),
      .rx_ready (rx_ready)
   );

   task automatic tick(input int unsigned n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   // Drive the first nbits of a LSB-first bit vector, one bit-time each
   task automatic drive_bits(input logic [9:0] bits, input int unsigned nbits);
      for (int unsigned i = 0; i < nbits; i++) begin
         rx = bits[i];
         tick(CPB);
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      logic [9:0] bits;
      bits = {stop, b, 1'b0};
      drive_bits(bits, 10);
      if (stop)
         tick(4);
   endtask

   task automatic bus_read(input logic [1:0] a, input logic [7:0] exp,
                           input logic exp_rdy, input string name);
      addr  = a;
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      check8({name, ".data"}, rd_data, exp);
      check1({name, ".valid"}, rd_valid, 1'b1);
      check1({name, ".ready"}, rx_ready, exp_rdy);
      tick();
      check1({name, ".valid_drop"}, rd_valid, 1'b0);
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
      addr    = a;
      wr_data = d;
      wr_en   = 1'b1;
      tick();
      wr_en   = 1'b0;
   endtask

   task automatic add(input op_t op, input logic [1:0] a, input logic [7:0] d,
                      input logic stop, input int unsigned n, input logic [7:0] exp,
                      input logic exp_rdy, input string name);
      vec_t v;
      v.op = op; v.a = a; v.d = d; v.stop = stop; v.n = n;
      v.exp = exp; v.exp_rdy = exp_rdy; v.name = name;
      vecs.push_back(v);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0] bits;

      rst = 1'b1; rx = 1'b1; rd_en = 1'b0; wr_en = 1'b0;
      addr = 2'd0; wr_data = 8'h00;
      tick(3);
      check8("reset.rd_data", rd_data, 8'h00);
      check1("reset.rd_valid", rd_valid, 1'b0);
      check1("reset.rx_ready", rx_ready, 1'b0);
      rst = 1'b0;
      tick(2);

      // Single byte 0x55: rx_ready rises exactly one cycle after the mid-stop sample
      bits = {1'b1, 8'h55, 1'b0};
      drive_bits(bits, 9);
      rx = 1'b1;
      tick(10);
      check1("latency.before", rx_ready, 1'b0);
      tick();
      check1("latency.after", rx_ready, 1'b1);
      tick(5);

      // Single byte follow-up and register map
      add(OP_READ,  2'd1, 8'h00, 1'b1, 0, 8'h01, 1'b1, "single.status");
      add(OP_READ,  2'd0, 8'h00, 1'b1, 0, 8'h55, 1'b0, "single.data");
      add(OP_READ,  2'd1, 8'h00, 1'b1, 0, 8'h00, 1'b0, "single.status_empty");
      add(OP_READ,  2'd0, 8'h00, 1'b1, 0, 8'h00, 1'b0, "single.data_empty");
      add(OP_READ,  2'd2, 8'h00, 1'b1, 0, 8'h00, 1'b0, "reserved2");
      add(OP_READ,  2'd3, 8'h00, 1'b1, 0, 8'h00, 1'b0, "reserved3");
      add(OP_WRITE, 2'd0, 8'hFF, 1'b1, 0, 8'h00, 1'b0, "write_data_ignored");
      add(OP_READ,  2'd1, 8'h00, 1'b1, 0, 8'h00, 1'b0, "single.status_after_wr");
      // Overrun
      add(OP_FRAME, 2'd0, 8'h01, 1'b1, 0, 8'h00, 1'b0, "ovr.f1");
      add(OP_FRAME, 2'd0, 8'h02, 1'b1, 0, 8'h00, 1'b0, "ovr.f2");
      add(OP_FRAME, 2'd0, 8'h03, 1'b1, 0, 8'h00, 1'b0, "ovr.f3");
      add(OP_FRAME, 2'd0, 8'h04, 1'b1, 0, 8'h00, 1'b0, "ovr.f4");
      add(OP_FRAME, 2'd0, 8'h05, 1'b1, 0, 8'h00, 1'b0, "ovr.f5");
      add(OP_READ,  2'd1, 8'h00, 1'b1, 0, 8'h0B, 1'b1, "ovr.status");
      add(OP_READ,  2'd0, 8'h00, 1'b1, 0, 8'h01, 1'b1, "ovr.d1");
      add(OP_READ,  2'd0, 8'h00, 1'b1, 0, 8'h02, 1'b1, "ovr.d2");
      add(OP_READ,  2'd0, 8'h00, 1'b1, 0, 8'h03, 1'b1, "ovr.d3");
      add(OP_READ,  2'd0, 8'h00, 1'b1, 0, 8'h04, 1'b0, "ovr.d4");
      add(OP_READ,  2'd0, 8'h00, 1'b1, 0, 8'h00, 1'b0, "ovr.d_empty");
      add(OP_READ,  2'd1, 8'h00, 1'b1, 0, 8'h02, 1'b0, "ovr.status_drained");
      add(OP_WRITE, 2'd1, 8'h02, 1'b1, 0, 8'h00, 1'b0, "ovr.clear");
      add(OP_READ,  2'd1, 8'h00, 1'b1, 0, 8'h00, 1'b0, "ovr.status_cleared");
      // Framing error and break
      add(OP_FRAME, 2'd0, 8'hA5, 1'b0, 0,   8'h00, 1'b0, "frm.bad");
      add(OP_LOW,   2'd0, 8'h00, 1'b0, 640, 8'h00, 1'b0, "frm.hold");
      add(OP_READ,  2'd1, 8'h00, 1'b1, 0,   8'h04, 1'b0, "frm.status_low");
      add(OP_HIGH,  2'd0, 8'h00, 1'b1, 20,  8'h00, 1'b0, "frm.release");
      add(OP_READ,  2'd1, 8'h00, 1'b1, 0,   8'h04, 1'b0, "frm.status_released");
      add(OP_FRAME, 2'd0, 8'h3C, 1'b1, 0,   8'h00, 1'b0, "frm.good");
      add(OP_READ,  2'd1, 8'h00, 1'b1, 0,   8'h05, 1'b1, "frm.status_good");
      add(OP_READ,  2'd0, 8'h00, 1'b1, 0,   8'h3C, 1'b0, "frm.data");
      add(OP_WRITE, 2'd1, 8'h02, 1'b1, 0,   8'h00, 1'b0, "frm.wrong_clear");
      add(OP_READ,  2'd1, 8'h00, 1'b1, 0,   8'h04, 1'b0, "frm.status_kept");
      add(OP_WRITE, 2'd1, 8'h04, 1'b1, 0,   8'h00, 1'b0, "frm.clear");
      add(OP_READ,  2'd1, 8'h00, 1'b1, 0,   8'h00, 1'b0, "frm.status_cleared");
      // Glitch on an idle line
      add(OP_LOW,   2'd0, 8'h00, 1'b0, 4,   8'h00, 1'b0, "glitch.low");
      add(OP_HIGH,  2'd0, 8'h00, 1'b1, 30,  8'h00, 1'b0, "glitch.high");
      add(OP_READ,  2'd1, 8'h00, 1'b1, 0,   8'h00, 1'b0, "glitch.status");
      add(OP_FRAME, 2'd0, 8'hC3, 1'b1, 0,   8'h00, 1'b0, "glitch.next");
      add(OP_READ,  2'd0, 8'h00, 1'b1, 0,   8'hC3, 1'b0, "glitch.data");

      foreach (vecs[i]) begin
         case (vecs[i].op)
            OP_FRAME: send_frame(vecs[i].d, vecs[i].stop);
            OP_READ:  bus_read(vecs[i].a, vecs[i].exp, vecs[i].exp_rdy, vecs[i].name);
            OP_WRITE: bus_write(vecs[i].a, vecs[i].d);
            OP_LOW:   begin rx = 1'b0; tick(vecs[i].n); end
            OP_HIGH:  begin rx = 1'b1; tick(vecs[i].n); end
            default:  ;
         endcase
      end

      // Full FIFO: DATA read in the same cycle as the push of the fifth byte
      send_frame(8'h10, 1'b1);
      send_frame(8'h11, 1'b1);
      send_frame(8'h12, 1'b1);
      send_frame(8'h13, 1'b1);
      bits = {1'b1, 8'h14, 1'b0};
      drive_bits(bits, 9);
      rx = 1'b1;
      tick(10);
      addr  = 2'd0;
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      check8("simul.data", rd_data, 8'h10);
      check1("simul.valid", rd_valid, 1'b1);
      tick(5);
      bus_read(2'd1, 8'h09, 1'b1, "simul.status");
      bus_read(2'd0, 8'h11, 1'b1, "simul.d11");
      bus_read(2'd0, 8'h12, 1'b1, "simul.d12");
      bus_read(2'd0, 8'h13, 1'b1, "simul.d13");
      bus_read(2'd0, 8'h14, 1'b0, "simul.d14");

      // Reset mid-frame with a queued byte and a pending framing error
      send_frame(8'h77, 1'b1);
      send_frame(8'h00, 1'b0);
      rx = 1'b1;
      tick(20);
      bus_read(2'd1, 8'h05, 1'b1, "rstmid.status_before");
      rx = 1'b0;
      tick(CPB);
      rx = 1'b1;
      tick(3 * CPB + CPB / 2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check1("rstmid.rx_ready", rx_ready, 1'b0);
      tick(100);
      bus_read(2'd1, 8'h00, 1'b0, "rstmid.status_after");
      bus_read(2'd0, 8'h00, 1'b0, "rstmid.data_empty");
      send_frame(8'h81, 1'b1);
      bus_read(2'd0, 8'h81, 1'b0, "rstmid.next_frame");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
